seg_disp_mux4: RTL



---
 rtl/seg_disp_mux4.sv | 102 ++++++++++
 1 files changed

// File: rtl/seg_disp_mux4.sv
// +-----------------------------------------------------------------------------+
// | Module   : seg_disp_mux4                                                    |
// | Purpose  : Four-digit multiplexed seven-segment driver (common anode,      |
// |            active-low). Frame-synchronous input snapshot, live digit mask.  |
// |            Optional per-slot blanking: define SEG_DISP_MUX_DEADTIME_EN.     |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

module seg_disp_mux4 #(
  parameter int REFRESH_M = 50_000,
  parameter int DEAD_M    = 500
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in3,
  input  logic [7:0] in2,
  input  logic [7:0] in1,
  input  logic [7:0] in0,
  input  logic [3:0] dig_en,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic       frame_tick
);

  localparam int              c_CW   = $clog2(REFRESH_M);
  localparam logic [c_CW-1:0] c_TERM = c_CW'(REFRESH_M - 1);

  logic [c_CW-1:0] r_cnt;
  logic [1:0]      r_idx;
  logic [7:0]      r_sh [4];
  logic            r_first;
  logic [3:0]      r_an;
  logic [7:0]      r_sseg;
  logic            r_ft;

  logic w_term;
  logic w_frame;
  logic w_dead;
  logic w_blank;

  assign w_term  = (r_cnt == c_TERM);
  assign w_frame = w_term && (r_idx == 2'd3);

`ifdef SEG_DISP_MUX_DEADTIME_EN
  // Blank the head of every slot so the previous anode has fully turned off.
  assign w_dead = (r_cnt < c_CW'(DEAD_M));
`else
  assign w_dead = 1'b0 && (DEAD_M >= 0);
`endif

  assign w_blank = !dig_en[r_idx] || w_dead;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_idx   <= 2'd0;
      r_first <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        r_sh[i] <= 8'hFF;
      end
    end else begin
      r_cnt <= w_term ? '0 : r_cnt + 1'b1;
      if (w_term) begin
        r_idx <= r_idx + 2'd1;
      end
      // Inputs are only sampled at the frame boundary (or right after reset),
      // so a pattern change can never tear across digits of one frame.
      if (r_first || w_frame) begin
        r_sh[0] <= in0;
        r_sh[1] <= in1;
        r_sh[2] <= in2;
        r_sh[3] <= in3;
      end
      r_first <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_an   <= 4'hF;
      r_sseg <= 8'hFF;
      r_ft   <= 1'b0;
    end else begin
      r_ft <= w_frame;
      if (w_blank) begin
        r_an   <= 4'hF;
        r_sseg <= 8'hFF;
      end else begin
        r_an   <= ~(4'b0001 << r_idx);
        r_sseg <= r_sh[r_idx];
      end
    end
  end

  assign an         = r_an;
  assign sseg       = r_sseg;
  assign frame_tick = r_ft;

endmodule

`default_nettype wire
